intr_svc_seq: RTL and testbench
===============================

Name: intr_svc_seq

Overview:
Sequencer between the APB interrupt controller (16 sources, 4-bit priority registers) and the processor core. After reset it acts as APB master and programs every priority register from a default table. It then forwards each granted interrupt to the core, tracks completion with a timeout, and returns the one-cycle serviced handshake to the controller. Between services it also carries runtime priority-update requests onto APB.

Parameters:
NUM_INTR, 16, number of interrupt sources and priority registers (max 16; address width 4)
TIMEOUT_CYC, 64, cycles allowed from cpu_irq_o rise to cpu_done_i before forced completion
CNT_W, 7, width of timeout counter (must hold TIMEOUT_CYC)

Ports:
pclk_i  in  1  clock, all logic on rising edge
prst_n_i  in  1  reset, asynchronous assert, active-low
paddr_o  out  4  APB address (priority register index)
pwdata_o  out  4  APB write data (priority value)
pwrite_o  out  1  APB write strobe
penable_o  out  1  APB enable
pready_i  in  1  APB ready from controller
pslverr_i  in  1  APB error from controller, sampled with pready_i
intr_valid_i  in  1  controller has a granted interrupt
intr_id_i  in  4  granted interrupt index
intr_serviced_o  out  1  one-cycle completion pulse to controller
cpu_irq_o  out  1  interrupt request level to core
cpu_vec_o  out  4  latched interrupt index presented to core
cpu_done_i  in  1  core finished handler (level or pulse)
upd_req_i  in  1  runtime priority update request
upd_addr_i  in  4  register index for update
upd_data_i  in  4  new priority
upd_ack_o  out  1  one-cycle pulse when update transfer completes
cfg_done_o  out  1  boot programming complete (sticky until reset)
cfg_err_o  out  1  sticky: any pslverr_i seen on any write
timeout_o  out  1  sticky: any service forced by timeout
timeout_id_o  out  4  index of most recent timed-out interrupt

Behaviour:
- Reset (async, prst_n_i=0): all outputs 0, FSM=CFG_WR, write index=0, counter=0. Reset mid-transfer drops penable_o/pwrite_o immediately; boot programming restarts from index 0.
- APB transfer (codebase style, no psel): paddr_o/pwdata_o/pwrite_o/penable_o driven together and held stable until a cycle where pready_i=1. All four then return to 0 for at least one cycle (GAP state). pslverr_i is sampled only when pready_i=1; if set, cfg_err_o is set.
- CFG_WR: writes register k with value NUM_INTR-1-k, for k=0..NUM_INTR-1. Each write is followed by CFG_GAP. After the last write, cfg_done_o=1 and the FSM goes to IDLE. intr_valid_i and upd_req_i are ignored until cfg_done_o is set.
- IDLE priority: if intr_valid_i=1, service wins. Otherwise, if upd_req_i=1, go to UPD_WR. Both sampled in the same cycle: service first, and the update stays pending (requester holds upd_req_i until upd_ack_o).
- SVC_REQ: on entry, latch intr_id_i into cpu_vec_o and set cpu_irq_o=1; counter starts at 0 and increments each cycle. Exit on cpu_done_i=1 or counter==TIMEOUT_CYC-1, whichever comes first. On timeout: set timeout_o, latch timeout_id_o=cpu_vec_o. If cpu_done_i=1 on the timeout cycle, no timeout is flagged.
- SVC_DONE: cpu_irq_o=0, intr_serviced_o=1 for exactly one cycle. Total latency from intr_valid_i in IDLE to intr_serviced_o is 2 cycles when cpu_done_i is already high.
- SVC_GAP: one cycle with intr_valid_i ignored, so the controller can drop valid or update its id. Then return to IDLE.
- UPD_WR: one APB write of upd_data_i to upd_addr_i, with both captured at entry. upd_ack_o pulses in the cycle after pready_i, then UPD_GAP, then IDLE. Interrupts arriving during UPD_WR wait until IDLE.
- intr_id_i changing during SVC_REQ has no effect; cpu_vec_o stays stable.
- pready_i never asserting: the FSM waits forever. There is no APB timeout.

Decomposition:
- Shared package intr_pkg: state encoding (CFG_WR, CFG_GAP, IDLE, SVC_REQ, SVC_DONE, SVC_GAP, UPD_WR, UPD_GAP), INTR_ID_W=4, PRIO_W=4.
- One sub-module, apb_wr_master: single-write engine (start, addr, data -> APB pins, done pulse, err pulse). It is shared by the CFG and UPD paths.

Test Plan:
- Boot: release reset with pready_i tied 1 -> 16 writes observed, addr 0..15, data 15..0, each followed by an idle cycle; cfg_done_o=1 after the last; cfg_err_o=0.
- Service: intr_valid_i=1, intr_id_i=5, cpu_done_i asserted 10 cycles after cpu_irq_o -> cpu_vec_o=5; intr_serviced_o pulses once, exactly 1 cycle after done; timeout_o=0.
- Timeout: intr_id_i=9, cpu_done_i held 0 -> intr_serviced_o pulses 64 cycles after cpu_irq_o rise; timeout_o=1; timeout_id_o=9.
- Collision: upd_req_i (addr 3, data 7) and intr_valid_i rise in the same IDLE cycle -> service completes first, then one APB write addr=3 data=7, then upd_ack_o pulse.
- APB stall and error: pready_i held low 5 cycles during boot write 4, pslverr_i=1 on its ready -> signals stable across the stall; cfg_err_o=1; boot continues to index 15.
- Async reset asserted mid-SVC_REQ -> all outputs 0 immediately, without a clock edge; after release, boot restarts from addr 0.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared types for the interrupt service sequencer: FSM state encoding,
// index/priority widths and the single-write request payload.
package intr_pkg;

  localparam int unsigned INTR_ID_W = 4;
  localparam int unsigned PRIO_W    = 4;

  typedef enum logic [2:0] {
    CFG_WR,
    CFG_GAP,
    IDLE,
    SVC_REQ,
    SVC_DONE,
    SVC_GAP,
    UPD_WR,
    UPD_GAP
  } seq_state_e;

  // One APB write: priority register index and value.
  typedef struct packed {
    logic [INTR_ID_W-1:0] addr;
    logic [PRIO_W-1:0]    data;
  } apb_wr_t;

endpackage

// File: rtl/intr_svc_seq_if.sv
// APB write bus between the sequencer (master) and the interrupt controller
// (slave). No psel: address, data, write and enable move together.
//   paddr_o/pwdata_o/pwrite_o/penable_o : master -> controller
//   pready_i/pslverr_i                  : controller -> master
interface intr_svc_seq_if;
  import intr_pkg::*;

  logic [INTR_ID_W-1:0] paddr_o;
  logic [PRIO_W-1:0]    pwdata_o;
  logic                 pwrite_o;
  logic                 penable_o;
  logic                 pready_i;
  logic                 pslverr_i;

  modport master (
    output paddr_o, pwdata_o, pwrite_o, penable_o,
    input  pready_i, pslverr_i
  );

  modport slave (
    input  paddr_o, pwdata_o, pwrite_o, penable_o,
    output pready_i, pslverr_i
  );

endinterface

// File: rtl/apb_wr_master.sv
// Single-write APB engine shared by boot programming and runtime updates.
// Ports: pclk_i/prst_n_i clock and async reset; start launches req when idle;
// busy is high while a transfer is on the bus; done_c/err_c flag the cycle
// in which pready_i completes the transfer (err_c when pslverr_i is set).
module apb_wr_master
  import intr_pkg::*;
(
  input  logic                  pclk_i,
  input  logic                  prst_n_i,
  input  logic                  start,
  input  apb_wr_t               req,
  output logic                  busy,
  output logic                  done_c,
  output logic                  err_c,
  intr_svc_seq_if.master        apb
);

  // The enable pin doubles as the busy flag.
  assign busy   = apb.penable_o;
  assign done_c = apb.penable_o & apb.pready_i;
  assign err_c  = done_c & apb.pslverr_i;

  // Pins load together on start and all drop together on completion.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      apb.paddr_o   <= '0;
      apb.pwdata_o  <= '0;
      apb.pwrite_o  <= 1'b0;
      apb.penable_o <= 1'b0;
    end else if (!apb.penable_o && start) begin
      apb.paddr_o   <= req.addr;
      apb.pwdata_o  <= req.data;
      apb.pwrite_o  <= 1'b1;
      apb.penable_o <= 1'b1;
    end else if (done_c) begin
      apb.paddr_o   <= '0;
      apb.pwdata_o  <= '0;
      apb.pwrite_o  <= 1'b0;
      apb.penable_o <= 1'b0;
    end
  end

endmodule

// File: rtl/intr_svc_seq.sv
// Interrupt service sequencer. Boots by writing priority NUM_INTR-1-k to
// register k over APB, then forwards granted interrupts to the core with a
// completion timeout and carries runtime priority updates onto APB.
// Ports: pclk_i/prst_n_i; apb (APB master bus); intr_valid_i/intr_id_i and
// intr_serviced_o to the controller; cpu_irq_o/cpu_vec_o/cpu_done_i to the
// core; upd_req_i/upd_addr_i/upd_data_i/upd_ack_o update request;
// cfg_done_o, cfg_err_o, timeout_o, timeout_id_o status.
module intr_svc_seq
  import intr_pkg::*;
#(
  parameter int unsigned NUM_INTR    = 16,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic                 pclk_i,
  input  logic                 prst_n_i,
  intr_svc_seq_if.master       apb,
  input  logic                 intr_valid_i,
  input  logic [INTR_ID_W-1:0] intr_id_i,
  output logic                 intr_serviced_o,
  output logic                 cpu_irq_o,
  output logic [INTR_ID_W-1:0] cpu_vec_o,
  input  logic                 cpu_done_i,
  input  logic                 upd_req_i,
  input  logic [INTR_ID_W-1:0] upd_addr_i,
  input  logic [PRIO_W-1:0]    upd_data_i,
  output logic                 upd_ack_o,
  output logic                 cfg_done_o,
  output logic                 cfg_err_o,
  output logic                 timeout_o,
  output logic [INTR_ID_W-1:0] timeout_id_o
);

  // One extra bit so the boot index can reach NUM_INTR without wrapping.
  localparam int unsigned IDX_W = INTR_ID_W + 1;

  seq_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [CNT_W-1:0]     cnt_q;
  apb_wr_t              upd_q;

  apb_wr_t              wr_req_c;
  logic                 wr_start_c, wr_busy, wr_done_c, wr_err_c;
  logic                 cnt_last_c, svc_enter_c, svc_exit_c, tmo_c;
  logic                 upd_enter_c, upd_fin_c, cfg_fin_c;

  apb_wr_master u_wr (
    .pclk_i   (pclk_i),
    .prst_n_i (prst_n_i),
    .start    (wr_start_c),
    .req      (wr_req_c),
    .busy     (wr_busy),
    .done_c   (wr_done_c),
    .err_c    (wr_err_c),
    .apb      (apb)
  );

  // State register.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) state_q <= CFG_WR;
    else           state_q <= state_d;
  end

  // Next-state logic. IDLE is only reachable after boot, which is what keeps
  // interrupts and updates out until cfg_done_o.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CFG_WR:   if (wr_done_c) state_d = CFG_GAP;
      CFG_GAP:  state_d = (idx_q == IDX_W'(NUM_INTR)) ? IDLE : CFG_WR;
      IDLE: begin
        if (intr_valid_i)   state_d = SVC_REQ;
        else if (upd_req_i) state_d = UPD_WR;
      end
      SVC_REQ:  if (cpu_done_i || cnt_last_c) state_d = SVC_DONE;
      SVC_DONE: state_d = SVC_GAP;
      SVC_GAP:  state_d = IDLE;
      UPD_WR:   if (wr_done_c) state_d = UPD_GAP;
      UPD_GAP:  state_d = IDLE;
      default:  state_d = CFG_WR;
    endcase
  end

  // Control strobes and write-engine request.
  always_comb begin
    wr_start_c    = 1'b0;
    wr_req_c.addr = INTR_ID_W'(idx_q);
    wr_req_c.data = PRIO_W'(NUM_INTR - 1) - PRIO_W'(idx_q);
    cnt_last_c    = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    svc_enter_c   = 1'b0;
    svc_exit_c    = 1'b0;
    tmo_c         = 1'b0;
    upd_enter_c   = 1'b0;
    upd_fin_c     = 1'b0;
    cfg_fin_c     = 1'b0;
    unique case (state_q)
      CFG_WR:  wr_start_c = !wr_busy;
      CFG_GAP: cfg_fin_c  = (idx_q == IDX_W'(NUM_INTR));
      IDLE: begin
        svc_enter_c = intr_valid_i;
        upd_enter_c = !intr_valid_i && upd_req_i;
      end
      SVC_REQ: begin
        svc_exit_c = cpu_done_i || cnt_last_c;
        tmo_c      = cnt_last_c && !cpu_done_i;
      end
      UPD_WR: begin
        wr_start_c = !wr_busy;
        wr_req_c   = upd_q;
        upd_fin_c  = wr_done_c;
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      idx_q           <= '0;
      cnt_q           <= '0;
      upd_q           <= '0;
      intr_serviced_o <= 1'b0;
      cpu_irq_o       <= 1'b0;
      cpu_vec_o       <= '0;
      upd_ack_o       <= 1'b0;
      cfg_done_o      <= 1'b0;
      cfg_err_o       <= 1'b0;
      timeout_o       <= 1'b0;
      timeout_id_o    <= '0;
    end else begin
      if (state_q == CFG_WR && wr_done_c) idx_q <= idx_q + IDX_W'(1);
      if (svc_enter_c)                    cnt_q <= '0;
      else if (state_q == SVC_REQ)        cnt_q <= cnt_q + CNT_W'(1);
      if (svc_enter_c) begin
        cpu_irq_o <= 1'b1;
        cpu_vec_o <= intr_id_i;
      end else if (svc_exit_c) begin
        cpu_irq_o <= 1'b0;
      end
      if (tmo_c) begin
        timeout_o    <= 1'b1;
        timeout_id_o <= cpu_vec_o;
      end
      if (upd_enter_c) begin
        upd_q.addr <= upd_addr_i;
        upd_q.data <= upd_data_i;
      end
      intr_serviced_o <= svc_exit_c;
      upd_ack_o       <= upd_fin_c;
      if (cfg_fin_c) cfg_done_o <= 1'b1;
      if (wr_err_c)  cfg_err_o  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_intr_svc_seq.sv
// Directed bench for intr_svc_seq: expected APB writes and serviced vectors
// are queued as stimulus is driven and popped as the DUT produces them.
module tb_intr_svc_seq;

  localparam int NUM_INTR = 16;
  localparam int TMO      = 64;

  typedef struct packed {
    logic [3:0] addr;
    logic [3:0] data;
  } wr_t;

  logic       pclk_i = 1'b0;
  logic       prst_n_i;
  logic       intr_valid_i;
  logic [3:0] intr_id_i;
  logic       intr_serviced_o;
  logic       cpu_irq_o;
  logic [3:0] cpu_vec_o;
  logic       cpu_done_i;
  logic       upd_req_i;
  logic [3:0] upd_addr_i;
  logic [3:0] upd_data_i;
  logic       upd_ack_o;
  logic       cfg_done_o;
  logic       cfg_err_o;
  logic       timeout_o;
  logic [3:0] timeout_id_o;

  int checks   = 0;
  int failures = 0;

  wr_t        exp_wr[$];
  logic [3:0] exp_svc[$];

  intr_svc_seq_if apb ();

  intr_svc_seq dut (
    .pclk_i          (pclk_i),
    .prst_n_i        (prst_n_i),
    .apb             (apb),
    .intr_valid_i    (intr_valid_i),
    .intr_id_i       (intr_id_i),
    .intr_serviced_o (intr_serviced_o),
    .cpu_irq_o       (cpu_irq_o),
    .cpu_vec_o       (cpu_vec_o),
    .cpu_done_i      (cpu_done_i),
    .upd_req_i       (upd_req_i),
    .upd_addr_i      (upd_addr_i),
    .upd_data_i      (upd_data_i),
    .upd_ack_o       (upd_ack_o),
    .cfg_done_o      (cfg_done_o),
    .cfg_err_o       (cfg_err_o),
    .timeout_o       (timeout_o),
    .timeout_id_o    (timeout_id_o)
  );

  always #5 pclk_i = ~pclk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_apb"}, {apb.paddr_o, apb.pwdata_o, apb.pwrite_o, apb.penable_o}, 0);
    chk({tag, "_core"}, {intr_serviced_o, cpu_irq_o, cpu_vec_o, upd_ack_o}, 0);
    chk({tag, "_status"}, {cfg_done_o, cfg_err_o, timeout_o, timeout_id_o}, 0);
  endtask

  task automatic push_boot();
    for (int k = 0; k < NUM_INTR; k++) begin
      wr_t w;
      w.addr = 4'(k);
      w.data = 4'(NUM_INTR - 1 - k);
      exp_wr.push_back(w);
    end
  endtask

  // Poll negedges until a transfer is on the bus, bounded.
  task automatic wait_write(output logic found);
    found = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (apb.penable_o === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge pclk_i);
    end
  endtask

  task automatic check_write(input string tag, output wr_t e);
    chk({tag, "_sb_nonempty"}, exp_wr.size() > 0, 1);
    e = (exp_wr.size() > 0) ? exp_wr.pop_front() : '0;
    chk({tag, "_addr"}, apb.paddr_o, e.addr);
    chk({tag, "_data"}, apb.pwdata_o, e.data);
    chk({tag, "_pwrite"}, apb.pwrite_o, 1);
  endtask

  task automatic wait_serviced(output int n);
    n = 0;
    while (intr_serviced_o !== 1'b1 && n < 200) begin
      @(negedge pclk_i);
      n++;
    end
  endtask

  task automatic check_svc(input string tag);
    logic [3:0] e;
    chk({tag, "_sb_nonempty"}, exp_svc.size() > 0, 1);
    e = (exp_svc.size() > 0) ? exp_svc.pop_front() : 4'h0;
    chk({tag, "_pulse"}, intr_serviced_o, 1);
    chk({tag, "_vec"}, cpu_vec_o, e);
    chk({tag, "_irq_low"}, cpu_irq_o, 0);
  endtask

  task automatic run_boot(input int stall_idx);
    logic found;
    wr_t  e;
    for (int k = 0; k < NUM_INTR; k++) begin
      wait_write(found);
      chk("boot_wr_seen", found, 1);
      if (!found) break;
      check_write("boot_wr", e);
      if (k == stall_idx) begin
        apb.pready_i = 1'b0;
        repeat (5) begin
          @(negedge pclk_i);
          chk("stall_stable", {apb.paddr_o, apb.pwdata_o, apb.pwrite_o, apb.penable_o},
              {e.addr, e.data, 2'b11});
        end
        chk("stall_no_err_yet", cfg_err_o, 0);
        apb.pready_i  = 1'b1;
        apb.pslverr_i = 1'b1;
      end
      @(negedge pclk_i);
      apb.pslverr_i = 1'b0;
      chk("boot_gap", {apb.pwrite_o, apb.penable_o}, 0);
      if (k == stall_idx) chk("stall_err_set", cfg_err_o, 1);
      if (k == NUM_INTR - 1) chk("cfg_done_not_early", cfg_done_o, 0);
    end
    @(negedge pclk_i);
    chk("cfg_done", cfg_done_o, 1);
  endtask

  initial begin
    int   n;
    logic found;
    wr_t  e;

    prst_n_i      = 1'b0;
    apb.pready_i  = 1'b1;
    apb.pslverr_i = 1'b0;
    intr_valid_i  = 1'b0;
    intr_id_i     = '0;
    cpu_done_i    = 1'b0;
    upd_req_i     = 1'b0;
    upd_addr_i    = '0;
    upd_data_i    = '0;

    repeat (2) @(negedge pclk_i);
    all_zero("reset");

    // Clean boot
    push_boot();
    prst_n_i = 1'b1;
    run_boot(-1);
    chk("cfg_err_clean", cfg_err_o, 0);

    // Service completed by core 10 cycles after irq; id changes mid-service
    @(negedge pclk_i);
    intr_id_i    = 4'd5;
    intr_valid_i = 1'b1;
    exp_svc.push_back(4'd5);
    @(negedge pclk_i);
    intr_valid_i = 1'b0;
    intr_id_i    = 4'd12;
    chk("svc_irq", cpu_irq_o, 1);
    chk("svc_vec_latch", cpu_vec_o, 4'd5);
    repeat (10) @(negedge pclk_i);
    chk("svc_vec_stable", cpu_vec_o, 4'd5);
    chk("svc_not_early", intr_serviced_o, 0);
    cpu_done_i = 1'b1;
    wait_serviced(n);
    cpu_done_i = 1'b0;
    chk("svc_latency", n, 1);
    check_svc("svc");
    @(negedge pclk_i);
    chk("svc_single_pulse", intr_serviced_o, 0);
    chk("svc_no_timeout", timeout_o, 0);

    // Timeout: core never completes
    repeat (2) @(negedge pclk_i);
    intr_id_i    = 4'd9;
    intr_valid_i = 1'b1;
    exp_svc.push_back(4'd9);
    @(negedge pclk_i);
    intr_valid_i = 1'b0;
    chk("tmo_irq", cpu_irq_o, 1);
    wait_serviced(n);
    chk("tmo_latency", n, TMO);
    check_svc("tmo");
    chk("tmo_flag", timeout_o, 1);
    chk("tmo_id", timeout_id_o, 4'd9);

    // Collision: service first, update stays pending
    repeat (3) @(negedge pclk_i);
    intr_id_i    = 4'd2;
    intr_valid_i = 1'b1;
    upd_req_i    = 1'b1;
    upd_addr_i   = 4'd3;
    upd_data_i   = 4'd7;
    exp_svc.push_back(4'd2);
    e.addr = 4'd3;
    e.data = 4'd7;
    exp_wr.push_back(e);
    @(negedge pclk_i);
    intr_valid_i = 1'b0;
    chk("col_svc_first", cpu_irq_o, 1);
    chk("col_no_apb_yet", apb.penable_o, 0);
    cpu_done_i = 1'b1;
    wait_serviced(n);
    cpu_done_i = 1'b0;
    chk("col_svc_latency", n, 1);
    check_svc("col_svc");
    wait_write(found);
    chk("upd_wr_seen", found, 1);
    check_write("upd_wr", e);
    chk("upd_ack_not_early", upd_ack_o, 0);
    @(negedge pclk_i);
    chk("upd_ack", upd_ack_o, 1);
    chk("upd_gap", apb.penable_o, 0);
    upd_req_i = 1'b0;
    @(negedge pclk_i);
    chk("upd_ack_single", upd_ack_o, 0);
    repeat (4) @(negedge pclk_i);
    chk("upd_no_repeat", apb.penable_o, 0);
    chk("timeout_sticky", timeout_o, 1);

    // Async reset in the middle of SVC_REQ, away from any clock edge
    intr_id_i    = 4'd6;
    intr_valid_i = 1'b1;
    @(negedge pclk_i);
    intr_valid_i = 1'b0;
    chk("rst_svc_irq", cpu_irq_o, 1);
    #2 prst_n_i = 1'b0;
    #1 all_zero("async_rst");

    // Boot again with a stalled, erroring write at index 4
    @(negedge pclk_i);
    push_boot();
    prst_n_i = 1'b1;
    run_boot(4);
    chk("cfg_err_sticky", cfg_err_o, 1);
    chk("sb_wr_drained", exp_wr.size(), 0);
    chk("sb_svc_drained", exp_svc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
